clint_mmio: RTL and testbench

- Memory-mapped responder for the core-local interrupt register window: msip, mtimecmp, mtime.
- Sits between the hart's uncached MMIO request port and the CSR file.
- Owns the msip and mtimecmp registers.
- Aliases mtime onto the CSR time counter: reads sample it, writes are forwarded through a one-cycle write pulse.
- Drives the machine software and machine timer interrupt-pending bits into the CSR file.

---
 rtl/clint_mmio_pkg.sv | 53 +++++
 rtl/clint_mmio_if.sv | 25 ++
 rtl/clint_mmio.sv | 127 ++++++++++++
 tb/tb_clint_mmio.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/clint_mmio_pkg.sv
// Shared definitions for the CLINT MMIO responder: window offsets, register
// selector, handshake states and the byte-merge / decode helpers.
package clint_mmio_pkg;

    localparam int BASE_OFFSET_W = 16;
    localparam logic [BASE_OFFSET_W-1:0] MSIP_OFF     = 16'h0000;
    localparam logic [BASE_OFFSET_W-1:0] MTIMECMP_OFF = 16'h4000;
    localparam logic [BASE_OFFSET_W-1:0] MTIME_OFF    = 16'hBFF8;

    typedef enum logic [1:0] {
        REG_MSIP     = 2'd0,
        REG_MTIMECMP = 2'd1,
        REG_MTIME    = 2'd2,
        REG_NONE     = 2'd3
    } clint_reg_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } clint_state_e;

    function automatic logic [63:0] strb_merge(input logic [63:0] old_val,
                                               input logic [63:0] new_val,
                                               input logic [7:0]  strb);
        logic [63:0] res;
        res = old_val;
        for (int i = 0; i < 8; i++) begin
            if (strb[i]) begin
                res[8*i +: 8] = new_val[8*i +: 8];
            end else begin
                res[8*i +: 8] = old_val[8*i +: 8];
            end
        end
        return res;
    endfunction

    // Misaligned offsets never hit a register, even if the upper bits match.
    function automatic clint_reg_e clint_decode(input logic [BASE_OFFSET_W-1:0] addr);
        clint_reg_e sel;
        if (addr[2:0] != 3'b000) begin
            sel = REG_NONE;
        end else begin
            case (addr)
                MSIP_OFF:     sel = REG_MSIP;
                MTIMECMP_OFF: sel = REG_MTIMECMP;
                MTIME_OFF:    sel = REG_MTIME;
                default:      sel = REG_NONE;
            endcase
        end
        return sel;
    endfunction

endpackage

// File: rtl/clint_mmio_if.sv
// Request/response bundle between the hart MMIO port and the CLINT responder.
interface clint_mmio_if;

    logic                                     req_valid;
    logic                                     req_ready;
    logic                                     req_we;
    logic [clint_mmio_pkg::BASE_OFFSET_W-1:0] req_addr;
    logic [63:0]                              req_wdata;
    logic [7:0]                               req_wstrb;
    logic                                     resp_valid;
    logic                                     resp_ready;
    logic [63:0]                              resp_rdata;
    logic                                     resp_err;

    modport hart (
        output req_valid, req_we, req_addr, req_wdata, req_wstrb, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport clint (
        input  req_valid, req_we, req_addr, req_wdata, req_wstrb, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );

endinterface

// File: rtl/clint_mmio.sv
// CLINT register window responder: owns msip/mtimecmp, aliases mtime onto the
// CSR time counter and drives the machine software/timer pending bits.
module clint_mmio
    import clint_mmio_pkg::*;
(
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_we,
    input  logic [BASE_OFFSET_W-1:0] req_addr,
    input  logic [63:0]              req_wdata,
    input  logic [7:0]               req_wstrb,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [63:0]              resp_rdata,
    output logic                     resp_err,
    input  logic [63:0]              time_rdata,
    output logic                     time_w_en,
    output logic [63:0]              time_w_data,
    output logic                     mip_msip,
    output logic                     mip_mtip
);

    clint_state_e state_q, state_d;
    logic [63:0]  resp_rdata_q, resp_rdata_d;
    logic         resp_err_q, resp_err_d;
    logic         msip_q, msip_d;
    logic [63:0]  mtimecmp_q, mtimecmp_d;
    logic         time_w_en_q, time_w_en_d;
    logic [63:0]  time_w_data_q, time_w_data_d;
    logic         mip_mtip_q, mip_mtip_d;
    logic         accept_s;
    clint_reg_e   reg_sel_s;

    assign resp_valid  = (state_q == ST_RESP);
    assign req_ready   = !resp_valid || resp_ready;
    assign accept_s    = req_valid && req_ready;
    assign reg_sel_s   = clint_decode(req_addr);

    assign resp_rdata  = resp_rdata_q;
    assign resp_err    = resp_err_q;
    assign time_w_en   = time_w_en_q;
    assign time_w_data = time_w_data_q;
    assign mip_msip    = msip_q;
    assign mip_mtip    = mip_mtip_q;

    // Next-state: handshake FSM, register decode and interrupt compare.
    always_comb begin
        state_d       = state_q;
        resp_rdata_d  = resp_rdata_q;
        resp_err_d    = resp_err_q;
        msip_d        = msip_q;
        mtimecmp_d    = mtimecmp_q;
        time_w_en_d   = 1'b0;
        time_w_data_d = time_w_data_q;

        case (state_q)
            ST_IDLE: begin
                if (accept_s) state_d = ST_RESP;
                else          state_d = ST_IDLE;
            end
            ST_RESP: begin
                if (accept_s)        state_d = ST_RESP;
                else if (resp_ready) state_d = ST_IDLE;
                else                 state_d = ST_RESP;
            end
            default: state_d = ST_IDLE;
        endcase

        if (accept_s) begin
            resp_rdata_d = 64'h0;
            resp_err_d   = 1'b0;
            case (reg_sel_s)
                REG_MSIP: begin
                    if (!req_we)          resp_rdata_d = {63'h0, msip_q};
                    else if (req_wstrb[0]) msip_d = req_wdata[0];
                    else                  msip_d = msip_q;
                end
                REG_MTIMECMP: begin
                    if (!req_we) resp_rdata_d = mtimecmp_q;
                    else         mtimecmp_d = strb_merge(mtimecmp_q, req_wdata, req_wstrb);
                end
                REG_MTIME: begin
                    // An empty strobe must not steal a cycle from the free-running count.
                    if (!req_we) begin
                        resp_rdata_d = time_rdata;
                    end else if (req_wstrb != 8'h00) begin
                        time_w_en_d   = 1'b1;
                        time_w_data_d = strb_merge(time_rdata, req_wdata, req_wstrb);
                    end else begin
                        time_w_en_d   = 1'b0;
                    end
                end
                default: resp_err_d = 1'b1;
            endcase
        end else begin
            resp_rdata_d = resp_rdata_q;
        end

        mip_mtip_d = (time_rdata >= mtimecmp_d);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            resp_rdata_q  <= 64'h0;
            resp_err_q    <= 1'b0;
            msip_q        <= 1'b0;
            mtimecmp_q    <= 64'hFFFF_FFFF_FFFF_FFFF;
            time_w_en_q   <= 1'b0;
            time_w_data_q <= 64'h0;
            mip_mtip_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            resp_rdata_q  <= resp_rdata_d;
            resp_err_q    <= resp_err_d;
            msip_q        <= msip_d;
            mtimecmp_q    <= mtimecmp_d;
            time_w_en_q   <= time_w_en_d;
            time_w_data_q <= time_w_data_d;
            mip_mtip_q    <= mip_mtip_d;
        end
    end

endmodule

// File: tb/tb_clint_mmio.sv
// Randomized and directed bench for clint_mmio against a register-level model.
module tb_clint_mmio;
    import clint_mmio_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_we;
    logic [15:0] req_addr;
    logic [63:0] req_wdata;
    logic [7:0]  req_wstrb;
    logic        resp_valid, resp_ready;
    logic [63:0] resp_rdata;
    logic        resp_err;
    logic [63:0] time_rdata;
    logic        time_w_en;
    logic [63:0] time_w_data;
    logic        mip_msip, mip_mtip;

    int checks = 0;
    int failures = 0;

    // Architectural model of the CLINT registers.
    logic        msip_m;
    logic [63:0] cmp_m;

    // Expected and observed results of the most recent transaction.
    logic [63:0] exp_rdata, exp_wdata, got_rdata, got_wdata;
    logic        exp_err, exp_wen, got_err, got_wen, got_wen_after, got_msip, got_mtip, got_ok;

    clint_mmio dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .time_rdata(time_rdata), .time_w_en(time_w_en), .time_w_data(time_w_data),
        .mip_msip(mip_msip), .mip_mtip(mip_mtip)
    );

    always #5 clock = ~clock;

    function automatic logic [63:0] byte_mask(input logic [7:0] s);
        logic [63:0] m;
        m = 64'h0;
        for (int i = 0; i < 8; i++) if (s[i]) m = m | (64'hFF << (8 * i));
        return m;
    endfunction

    // Computes the expected response and applies the side effects to the model.
    task automatic model_txn(input logic we, input logic [15:0] addr, input logic [63:0] wd,
                             input logic [7:0] ws, input logic [63:0] trd);
        logic [63:0] m;
        m = byte_mask(ws);
        exp_rdata = 64'h0; exp_err = 1'b0; exp_wen = 1'b0; exp_wdata = 64'h0;
        if ((addr % 16'd8) != 16'd0) exp_err = 1'b1;
        else if (addr == 16'h0000) begin
            if (!we) exp_rdata = {63'h0, msip_m};
            else if (ws[0]) msip_m = wd[0];
        end else if (addr == 16'h4000) begin
            if (!we) exp_rdata = cmp_m;
            else cmp_m = (cmp_m & ~m) | (wd & m);
        end else if (addr == 16'hBFF8) begin
            if (!we) exp_rdata = trd;
            else if (ws != 8'h00) begin exp_wen = 1'b1; exp_wdata = (trd & ~m) | (wd & m); end
        end else exp_err = 1'b1;
    endtask

    // Drives one request with resp_ready high, captures the response, lets it retire.
    task automatic issue(input logic we, input logic [15:0] addr, input logic [63:0] wd,
                         input logic [7:0] ws);
        model_txn(we, addr, wd, ws, time_rdata);
        got_ok = 1'b0;
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; req_wstrb = ws;
        resp_ready = 1'b1;
        for (int c = 0; c < 20 && !got_ok; c++) begin
            if (req_ready === 1'b1) got_ok = 1'b1;
            @(posedge clock); #1;
        end
        req_valid = 1'b0;
        checks++;
        if (!got_ok || resp_valid !== 1'b1) begin
            failures++;
            $display("FAIL accept_timeout addr=%h got_valid=%b exp_valid=1", addr, resp_valid);
        end
        got_rdata = resp_rdata; got_err = resp_err; got_wen = time_w_en; got_wdata = time_w_data;
        got_msip = mip_msip; got_mtip = mip_mtip;
        @(posedge clock); #1;
        got_wen_after = time_w_en;
    endtask

    task automatic do_reset();
        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = 16'h0;
        req_wdata = 64'h0; req_wstrb = 8'h0; resp_ready = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        msip_m = 1'b0; cmp_m = 64'hFFFF_FFFF_FFFF_FFFF;
    endtask

    task automatic test_reset();
        time_rdata = 64'h0;
        do_reset();
        checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL rst_resp_valid got=%b exp=0", resp_valid); end
        checks++; if (resp_rdata !== 64'h0 || resp_err !== 1'b0) begin failures++; $display("FAIL rst_resp got=%h/%b exp=0/0", resp_rdata, resp_err); end
        checks++; if (time_w_en !== 1'b0 || time_w_data !== 64'h0) begin failures++; $display("FAIL rst_time_w got=%b/%h exp=0/0", time_w_en, time_w_data); end
        checks++; if (mip_msip !== 1'b0 || mip_mtip !== 1'b0) begin failures++; $display("FAIL rst_mip got=%b%b exp=00", mip_msip, mip_mtip); end
        reset = 1'b0;
        issue(1'b0, 16'h4000, 64'h0, 8'h00);
        checks++; if (got_rdata !== 64'hFFFF_FFFF_FFFF_FFFF || got_err !== 1'b0) begin failures++; $display("FAIL rst_cmp_read got=%h/%b exp=ffffffffffffffff/0", got_rdata, got_err); end
        checks++; if (got_mtip !== 1'b0 || mip_mtip !== 1'b0) begin failures++; $display("FAIL rst_mtip got=%b/%b exp=0", got_mtip, mip_mtip); end
    endtask

    task automatic test_timer();
        time_rdata = 64'd100;
        issue(1'b1, 16'h4000, 64'd150, 8'hFF);
        checks++; if (got_mtip !== 1'b0) begin failures++; $display("FAIL mtip_below got=%b exp=0", got_mtip); end
        time_rdata = 64'd150;
        @(posedge clock); #1;
        checks++; if (mip_mtip !== 1'b1) begin failures++; $display("FAIL mtip_equal got=%b exp=1", mip_mtip); end
        issue(1'b1, 16'h4000, 64'd200, 8'hFF);
        checks++; if (got_mtip !== 1'b0) begin failures++; $display("FAIL mtip_rearm got=%b exp=0", got_mtip); end
        issue(1'b1, 16'h4000, 64'h0000_0000_0000_0001, 8'h02);
        checks++; if (got_mtip !== 1'b0) begin failures++; $display("FAIL mtip_byte1 got=%b exp=0", got_mtip); end
        issue(1'b0, 16'h4000, 64'h0, 8'h00);
        checks++; if (got_rdata !== 64'd200) begin failures++; $display("FAIL cmp_byte_merge got=%h exp=%h", got_rdata, 64'd200); end
    endtask

    task automatic test_msip();
        issue(1'b1, 16'h0000, 64'h1, 8'h01);
        checks++; if (got_msip !== 1'b1) begin failures++; $display("FAIL msip_set got=%b exp=1", got_msip); end
        issue(1'b1, 16'h0000, 64'h0, 8'h02);
        checks++; if (mip_msip !== 1'b1) begin failures++; $display("FAIL msip_strb got=%b exp=1", mip_msip); end
        issue(1'b0, 16'h0000, 64'h0, 8'h00);
        checks++; if (got_rdata !== 64'h1) begin failures++; $display("FAIL msip_read got=%h exp=1", got_rdata); end
        issue(1'b1, 16'h0000, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF);
        checks++; if (got_msip !== 1'b0) begin failures++; $display("FAIL msip_clear got=%b exp=0", got_msip); end
    endtask

    task automatic test_mtime();
        time_rdata = 64'h0000_0001_0000_0000;
        issue(1'b1, 16'hBFF8, 64'h5, 8'h0F);
        checks++; if (got_wen !== 1'b1 || got_wdata !== 64'h0000_0001_0000_0005) begin failures++; $display("FAIL mtime_write got=%b/%h exp=1/0000000100000005", got_wen, got_wdata); end
        checks++; if (got_wen_after !== 1'b0) begin failures++; $display("FAIL mtime_pulse_len got=%b exp=0", got_wen_after); end
        issue(1'b0, 16'hBFF8, 64'h0, 8'h00);
        checks++; if (got_rdata !== 64'h0000_0001_0000_0000 || got_wen !== 1'b0) begin failures++; $display("FAIL mtime_read got=%h/%b exp=0000000100000000/0", got_rdata, got_wen); end
        issue(1'b1, 16'hBFF8, 64'h1234, 8'h00);
        checks++; if (got_wen !== 1'b0 || got_err !== 1'b0) begin failures++; $display("FAIL mtime_nostrb got=%b/%b exp=0/0", got_wen, got_err); end
    endtask

    task automatic test_errors();
        issue(1'b0, 16'h0010, 64'h0, 8'h00);
        checks++; if (got_err !== 1'b1 || got_rdata !== 64'h0) begin failures++; $display("FAIL err_unmapped got=%b/%h exp=1/0", got_err, got_rdata); end
        issue(1'b1, 16'h4004, 64'h0, 8'hFF);
        checks++; if (got_err !== 1'b1 || got_rdata !== 64'h0) begin failures++; $display("FAIL err_misaligned got=%b/%h exp=1/0", got_err, got_rdata); end
        issue(1'b0, 16'h4000, 64'h0, 8'h00);
        checks++; if (got_rdata !== cmp_m || got_rdata !== 64'd200) begin failures++; $display("FAIL err_no_change got=%h exp=%h", got_rdata, 64'd200); end
        issue(1'b1, 16'h4000, 64'h0, 8'h00);
        checks++; if (got_err !== 1'b0) begin failures++; $display("FAIL nostrb_err got=%b exp=0", got_err); end
    endtask

    task automatic test_back_to_back();
        logic [63:0] first_exp;
        model_txn(1'b0, 16'h4000, 64'h0, 8'h00, time_rdata);
        first_exp = exp_rdata;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h4000; resp_ready = 1'b0;
        @(posedge clock); #1;
        req_addr = 16'h0000;
        model_txn(1'b0, 16'h0000, 64'h0, 8'h00, time_rdata);
        for (int k = 0; k < 3; k++) begin
            checks++; if (req_ready !== 1'b0 || resp_valid !== 1'b1 || resp_rdata !== first_exp) begin
                failures++; $display("FAIL stall_%0d got=%b/%b/%h exp=0/1/%h", k, req_ready, resp_valid, resp_rdata, first_exp); end
            @(posedge clock); #1;
        end
        resp_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready got=%b exp=1", req_ready); end
        @(posedge clock); #1;
        req_valid = 1'b0;
        checks++; if (resp_valid !== 1'b1 || resp_rdata !== exp_rdata || resp_err !== 1'b0) begin failures++; $display("FAIL b2b_resp got=%b/%h exp=1/%h", resp_valid, resp_rdata, exp_rdata); end
        @(posedge clock); #1;
        checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL b2b_retire got=%b exp=0", resp_valid); end
    endtask

    task automatic test_reset_mid();
        req_valid = 1'b1; req_we = 1'b1; req_addr = 16'h0000; req_wdata = 64'h1; req_wstrb = 8'h01;
        resp_ready = 1'b0;
        @(posedge clock); #1;
        req_valid = 1'b0;
        reset = 1'b1;
        @(posedge clock); #1;
        checks++; if (resp_valid !== 1'b0 || mip_msip !== 1'b0 || mip_mtip !== 1'b0) begin failures++; $display("FAIL mid_reset got=%b%b%b exp=000", resp_valid, mip_msip, mip_mtip); end
        do_reset();
        reset = 1'b0;
    endtask

    task automatic test_random();
        logic [15:0] a;
        logic [7:0]  ws;
        logic        we;
        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 5))
                0: a = 16'h0000;
                1: a = 16'h4000;
                2: a = 16'hBFF8;
                3: a = 16'($urandom) & 16'hFFF8;
                4: a = 16'($urandom);
                default: a = 16'h4000 | 16'($urandom_range(1, 7));
            endcase
            case ($urandom_range(0, 3))
                0: ws = 8'h00;
                1: ws = 8'hFF;
                default: ws = 8'($urandom);
            endcase
            we = 1'($urandom);
            if ($urandom_range(0, 1) == 0) time_rdata = cmp_m + 64'($urandom_range(0, 2)) - 64'd1;
            else time_rdata = {$urandom, $urandom};
            issue(we, a, {$urandom, $urandom}, ws);
            checks++; if (got_rdata !== exp_rdata || got_err !== exp_err) begin failures++; $display("FAIL rnd_resp n=%0d addr=%h got=%h/%b exp=%h/%b", n, a, got_rdata, got_err, exp_rdata, exp_err); end
            checks++; if (got_wen !== exp_wen || (exp_wen && got_wdata !== exp_wdata) || got_wen_after !== 1'b0) begin failures++; $display("FAIL rnd_time_w n=%0d got=%b/%h exp=%b/%h", n, got_wen, got_wdata, exp_wen, exp_wdata); end
            checks++; if (got_msip !== msip_m || got_mtip !== (time_rdata >= cmp_m)) begin failures++; $display("FAIL rnd_mip n=%0d got=%b%b exp=%b%b", n, got_msip, got_mtip, msip_m, time_rdata >= cmp_m); end
        end
    endtask

    initial begin
        test_reset();
        test_timer();
        test_msip();
        test_mtime();
        test_errors();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
